// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the clock phase/frequency monitor.
package clk_mon_pkg;

  localparam int          CW_DEF      = 16;
  localparam int unsigned TIMEOUT_DEF = 32'h0000_FFF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_M = 2'd1,
    MEAS   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// Input-to-pulse latency is 3 clk cycles.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;
  logic rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1     <= d;
      s2     <= s1;
      s3     <= s2;
      rise_q <= s2 & ~s3;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/clk_phase_mon.sv
// Measures one mclk period, one bclk period and the bclk-vs-mclk rising-edge
// phase offset in sampling-clock cycles, then reports per_b - per_m.
module clk_phase_mon
  import clk_mon_pkg::*;
#(
  parameter int          CW      = CW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mclk_in,
  input  logic              bclk_in,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CW-1:0]     per_m,
  output logic [CW-1:0]     per_b,
  output logic [CW-1:0]     phase,
  output logic signed [CW:0] freq_diff,
  output logic [1:0]        state_dbg
);

  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  // Handshake: start is a single-cycle request honoured only in IDLE and not
  // in the cycle timeout is pulsing; busy covers WAIT_M/MEAS, and each
  // accepted start ends with exactly one done or one timeout pulse.

  state_t state_q, state_d;

  logic m_rise;
  logic b_rise;

  logic [CW-1:0] ts_q;
  logic [CW-1:0] t1_q, t2_q, t4_q, t5_q;
  logic          got_t2_q, got_t4_q, got_t5_q;
  logic          timeout_q;
  logic [CW-1:0] per_m_q, per_b_q, phase_q;
  logic signed [CW:0] freq_diff_q;

  logic accept, cap_t1, cap_t2, cap_t4, cap_t5, fire_to, go_done;
  logic [CW-1:0] t2_v, t4_v, t5_v;
  logic [CW-1:0] per_m_nx, per_b_nx, phase_nx;
  logic signed [CW:0] freq_diff_nx;

  edge_sync u_sync_m (.clk(clk), .rst_n(rst_n), .d(mclk_in), .rise(m_rise));
  edge_sync u_sync_b (.clk(clk), .rst_n(rst_n), .d(bclk_in), .rise(b_rise));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cap_t1  = 1'b0;
    cap_t2  = 1'b0;
    cap_t4  = 1'b0;
    cap_t5  = 1'b0;
    fire_to = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !timeout_q) begin
          accept  = 1'b1;
          state_d = WAIT_M;
        end
      end
      WAIT_M: begin
        if (ts_q == TO_LIM) begin
          fire_to = 1'b1;
          state_d = IDLE;
        end else if (m_rise) begin
          cap_t1  = 1'b1;
          cap_t4  = b_rise;
          state_d = MEAS;
        end
      end
      MEAS: begin
        cap_t2 = m_rise & ~got_t2_q;
        cap_t4 = b_rise & ~got_t4_q;
        cap_t5 = b_rise & got_t4_q & ~got_t5_q;
        if (ts_q == TO_LIM) begin
          fire_to = 1'b1;
          state_d = IDLE;
        end else if ((got_t2_q | cap_t2) && (got_t4_q | cap_t4) && (got_t5_q | cap_t5)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Results are formed from this cycle's captures so they land with done.
  assign go_done      = (state_q == MEAS) && (state_d == DONE);
  assign t2_v         = cap_t2 ? ts_q : t2_q;
  assign t4_v         = cap_t4 ? ts_q : t4_q;
  assign t5_v         = cap_t5 ? ts_q : t5_q;
  assign per_m_nx     = t2_v - t1_q;
  assign per_b_nx     = t5_v - t4_v;
  assign phase_nx     = t4_v - t1_q;
  assign freq_diff_nx = $signed({1'b0, per_b_nx}) - $signed({1'b0, per_m_nx});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q        <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      t4_q        <= '0;
      t5_q        <= '0;
      got_t2_q    <= 1'b0;
      got_t4_q    <= 1'b0;
      got_t5_q    <= 1'b0;
      timeout_q   <= 1'b0;
      per_m_q     <= '0;
      per_b_q     <= '0;
      phase_q     <= '0;
      freq_diff_q <= '0;
    end else begin
      timeout_q <= fire_to;
      if (accept) begin
        ts_q     <= '0;
        got_t2_q <= 1'b0;
        got_t4_q <= 1'b0;
        got_t5_q <= 1'b0;
      end else if (state_q == WAIT_M || state_q == MEAS) begin
        ts_q <= ts_q + 1'b1;
      end
      if (cap_t1) t1_q <= ts_q;
      if (cap_t2) begin
        t2_q     <= ts_q;
        got_t2_q <= 1'b1;
      end
      if (cap_t4) begin
        t4_q     <= ts_q;
        got_t4_q <= 1'b1;
      end
      if (cap_t5) begin
        t5_q     <= ts_q;
        got_t5_q <= 1'b1;
      end
      if (go_done) begin
        per_m_q     <= per_m_nx;
        per_b_q     <= per_b_nx;
        phase_q     <= phase_nx;
        freq_diff_q <= freq_diff_nx;
      end
    end
  end

  assign busy      = (state_q == WAIT_M) || (state_q == MEAS);
  assign done      = (state_q == DONE);
  assign timeout   = timeout_q;
  assign per_m     = per_m_q;
  assign per_b     = per_b_q;
  assign phase     = phase_q;
  assign freq_diff = freq_diff_q;
  assign state_dbg = state_q;

endmodule

// File: doc/clk_phase_mon.md
# clk_phase_mon

Hardware clock-quality monitor placed directly downstream of `clk_buf`. It samples the master clock (`mclk`) and the buffered clock (`bclk`) with a fast sampling clock. On request it measures one period of each and the rising-edge phase offset of `bclk` relative to `mclk`, then reports the frequency difference. This gives a synthesizable on-chip check of the buffer's frequency and phase fidelity.

## Interface
Parameters:
- `CW`, 16: width of the timestamp counter and of the period/phase results.
- `TIMEOUT`, 16'hFFF0: sample-clock cycles allowed per measurement before it is aborted. Must be less than 2^CW.

Ports:
- `clk`, in, 1: sampling clock. Must be at least 4x the faster of `mclk_in`/`bclk_in`.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins a measurement. Ignored while `busy`.
- `mclk_in`, in, 1: master clock, asynchronous to `clk`.
- `bclk_in`, in, 1: buffered clock (`clk_buf` output), asynchronous to `clk`.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done` or `timeout`.
- `done`, out, 1: one-cycle pulse; results valid and held.
- `timeout`, out, 1: one-cycle pulse; the measurement was aborted.
- `per_m`, out, CW: `mclk` period, in `clk` cycles.
- `per_b`, out, CW: `bclk` period, in `clk` cycles.
- `phase`, out, CW: `bclk` first rise minus `mclk` first rise, in `clk` cycles.
- `freq_diff`, out, CW+1 signed: `per_b - per_m`.

## Operation
- Each input passes through a 2-flop synchronizer followed by rising-edge detection, giving `m_rise` and `b_rise`. Both paths have identical latency, so differences are unaffected.
- A timestamp counter `ts` clears on an accepted `start` and increments every cycle while `busy`.
- FSM states and transitions:
  - IDLE: `start` goes to WAIT_M.
  - WAIT_M: on `m_rise`, capture t1=`ts` and go to MEAS. `b_rise` is ignored in this state unless it occurs in the same cycle as `m_rise`.
  - MEAS: capture t2 on the next `m_rise`. Capture t4 on the first `b_rise` at or after t1, including the t1 cycle itself. Capture t5 on the following `b_rise`. Once t2, t4 and t5 are all captured, go to DONE.
  - DONE: register results, pulse `done`, return to IDLE.
- Results:
  - `per_m`=t2−t1.
  - `per_b`=t5−t4.
  - `phase`=t4−t1, which is never negative.
  - `freq_diff` is computed in CW+1 bits, sign-extended.
- Timeout: if `ts` reaches TIMEOUT in WAIT_M or MEAS, pulse `timeout` and go to IDLE. Result outputs keep their previous values. `ts` cannot wrap because TIMEOUT < 2^CW.
- Any `start` while not in IDLE is ignored.

## Timing
- Reset value of every output and register is 0, and the FSM resets to IDLE.
- Input-to-edge latency is 3 `clk` cycles (2 sync + 1 edge register), identical for both inputs.
- `busy` rises 1 cycle after an accepted `start`.
- `done` asserts 1 cycle after the last required edge is captured. Results update in the same cycle as `done`.
- `busy` falls in the same cycle that `done` or `timeout` pulses.
- `start` is accepted in the same cycle that `busy` falls back to IDLE? No: `start` is accepted only when the FSM is already in IDLE, i.e. from the cycle after `done`/`timeout`.
- `rst_n` low mid-measurement clears everything immediately. No `done` or `timeout` pulse is issued.

## Structure
- Package `clk_mon_pkg` holds:
  - the state enum (IDLE, WAIT_M, MEAS, DONE);
  - default constants for CW and TIMEOUT.
- Sub-module `edge_sync`: 2-flop synchronizer plus rising-edge pulse, with asynchronous active-low reset. It is instantiated once for `mclk_in` and once for `bclk_in`.

## Test plan
- `mclk` period 20 `clk`; `bclk` has the same period, delayed 3 cycles; pulse `start`. Required: `per_m`=20, `per_b`=20, `phase`=3, `freq_diff`=0, a single `done` pulse.
- `bclk` period 24, `mclk` period 20, rises aligned. Required: `phase`=0, `freq_diff`=+4.
- `bclk` period 16, delay 5. Required: `freq_diff`=−4, `phase`=5.
- `bclk` held low, TIMEOUT=100. Required: `timeout` pulses about 100 cycles after `start`, no `done`, results keep their prior values.
- `start` pulsed again while `busy`. Required: ignored, and exactly one `done` is seen.
- `rst_n` asserted in MEAS. Required: all outputs 0 immediately. A fresh `start` after release then measures correctly.
